// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - N-master bus arbiter, fixed-priority or round-robin, with BUSY-hold timeout
module bus_arbiter #(
    parameter int N_MASTERS = 8,
    parameter int RR_MODE   = 0,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [N_MASTERS-1:0]         dma,
    input  logic                         ready,
    output logic [N_MASTERS-1:0]         grant,
    output logic                         req,
    output logic [$clog2(N_MASTERS)-1:0] owner,
    output logic                         busy,
    output logic                         timeout
);

    localparam int OW = $clog2(N_MASTERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [N_MASTERS-1:0] ONE_HOT = {{(N_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                 state_q;
    logic [N_MASTERS-1:0]   grant_q;
    logic [OW-1:0]          owner_q;
    logic [OW-1:0]          last_owner_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   timeout_q;

    logic                   win_found;
    logic [OW-1:0]          win_idx;
    logic [N_MASTERS-1:0]   win_oh;

    function automatic logic [OW-1:0] pick_fixed(input logic [N_MASTERS-1:0] r);
        pick_fixed = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (r[i]) pick_fixed = OW'(i);
        end
    endfunction

    // Walk offsets from far to near so the nearest requester above last wins.
    function automatic logic [OW-1:0] pick_rr(input logic [N_MASTERS-1:0] r,
                                              input logic [OW-1:0]        last);
        logic [OW:0] sum;
        pick_rr = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            sum = {1'b0, last} + (OW+1)'(k);
            if (sum >= (OW+1)'(N_MASTERS)) sum = sum - (OW+1)'(N_MASTERS);
            if (r[sum[OW-1:0]]) pick_rr = sum[OW-1:0];
        end
    endfunction

    assign win_found = |dma;
    assign win_idx   = (RR_MODE != 0) ? pick_rr(dma, last_owner_q) : pick_fixed(dma);
    assign win_oh    = win_found ? (ONE_HOT << win_idx) : '0;

    always_comb begin
        grant = '0;
        owner = '0;
        if (state_q == S_BUSY) begin
            grant = grant_q;
            owner = owner_q;
        end else if (clr && win_found) begin
            grant = win_oh;
            owner = win_idx;
        end
    end

    assign req     = |grant;
    assign busy    = (state_q == S_BUSY);
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= OW'(N_MASTERS - 1);
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        if (ready) begin
                            last_owner_q <= win_idx;
                        end else begin
                            state_q <= S_BUSY;
                            grant_q <= win_oh;
                            owner_q <= win_idx;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    if (ready) begin
                        state_q      <= S_IDLE;
                        grant_q      <= '0;
                        owner_q      <= '0;
                        last_owner_q <= owner_q;
                        cnt_q        <= '0;
                    end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                        state_q      <= S_IDLE;
                        grant_q      <= '0;
                        owner_q      <= '0;
                        last_owner_q <= owner_q;
                        cnt_q        <= '0;
                        timeout_q    <= 1'b1;
                    end else if (TIMEOUT != 0 && cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter in fixed, RR and timeout configs
module tb_bus_arbiter;

    logic clk;
    logic clr;

    logic [7:0] dma_f, grant_f;
    logic       rdy_f, req_f, busy_f, to_f;
    logic [2:0] owner_f;

    logic [7:0] dma_r, grant_r;
    logic       rdy_r, req_r, busy_r, to_r;
    logic [2:0] owner_r;

    logic [4:0] dma_5, grant_5;
    logic       rdy_5, req_5, busy_5, to_5;
    logic [2:0] owner_5;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.N_MASTERS(8), .RR_MODE(0), .TIMEOUT(4), .CNT_W(8)) u_fix (
        .clk(clk), .clr(clr), .dma(dma_f), .ready(rdy_f), .grant(grant_f),
        .req(req_f), .owner(owner_f), .busy(busy_f), .timeout(to_f));

    bus_arbiter #(.N_MASTERS(8), .RR_MODE(1), .TIMEOUT(0), .CNT_W(8)) u_rr (
        .clk(clk), .clr(clr), .dma(dma_r), .ready(rdy_r), .grant(grant_r),
        .req(req_r), .owner(owner_r), .busy(busy_r), .timeout(to_r));

    bus_arbiter #(.N_MASTERS(5), .RR_MODE(1), .TIMEOUT(255), .CNT_W(8)) u_rr5 (
        .clk(clk), .clr(clr), .dma(dma_5), .ready(rdy_5), .grant(grant_5),
        .req(req_5), .owner(owner_5), .busy(busy_5), .timeout(to_5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        dma_f = 8'hFF; dma_r = 8'hFF;
        #2;
        checks++;
        if (grant_f !== 8'h00 || req_f !== 1'b0 || busy_f !== 1'b0 || owner_f !== 3'd0 || to_f !== 1'b0) begin
            errors++;
            $display("FAIL reset_gate grant=%h req=%b busy=%b owner=%0d to=%b exp 00/0/0/0/0", grant_f, req_f, busy_f, owner_f, to_f);
        end
        tick();
        clr = 1'b1;
        #2;
        checks++;
        if (grant_f !== 8'h01) begin
            errors++;
            $display("FAIL reset_fixed_first grant=%h exp 01", grant_f);
        end
        checks++;
        if (grant_r !== 8'h01 || owner_r !== 3'd0) begin
            errors++;
            $display("FAIL reset_rr_first grant=%h owner=%0d exp 01/0", grant_r, owner_r);
        end
        dma_f = 8'h00; dma_r = 8'h00;
    endtask

    task automatic test_fixed_hold();
        tick();
        dma_f = 8'b00101100; rdy_f = 1'b0;
        #2;
        checks++;
        if (grant_f !== 8'h04 || busy_f !== 1'b0) begin
            errors++;
            $display("FAIL fixed_idle grant=%h busy=%b exp 04/0", grant_f, busy_f);
        end
        tick();
        #2;
        checks++;
        if (grant_f !== 8'h04 || owner_f !== 3'd2 || busy_f !== 1'b1 || req_f !== 1'b1) begin
            errors++;
            $display("FAIL fixed_busy grant=%h owner=%0d busy=%b exp 04/2/1", grant_f, owner_f, busy_f);
        end
        dma_f = 8'b00000001;
        #1;
        checks++;
        if (grant_f !== 8'h04 || owner_f !== 3'd2) begin
            errors++;
            $display("FAIL fixed_hold grant=%h owner=%0d exp 04/2", grant_f, owner_f);
        end
        rdy_f = 1'b1;
        tick();
        #2;
        checks++;
        if (grant_f !== 8'h01 || busy_f !== 1'b0 || to_f !== 1'b0) begin
            errors++;
            $display("FAIL fixed_release grant=%h busy=%b to=%b exp 01/0/0", grant_f, busy_f, to_f);
        end
        dma_f = 8'h00; rdy_f = 1'b0;
    endtask

    task automatic test_timeout();
        tick();
        dma_f = 8'b00010000; rdy_f = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #2;
            checks++;
            if (busy_f !== 1'b1 || to_f !== 1'b0 || grant_f !== 8'h10) begin
                errors++;
                $display("FAIL timeout_busy%0d busy=%b to=%b grant=%h exp 1/0/10", i, busy_f, to_f, grant_f);
            end
        end
        tick();
        #2;
        checks++;
        if (busy_f !== 1'b0 || to_f !== 1'b1 || grant_f !== 8'h10) begin
            errors++;
            $display("FAIL timeout_pulse busy=%b to=%b grant=%h exp 0/1/10", busy_f, to_f, grant_f);
        end
        tick();
        #2;
        checks++;
        if (busy_f !== 1'b1 || to_f !== 1'b0 || owner_f !== 3'd4) begin
            errors++;
            $display("FAIL timeout_regrant busy=%b to=%b owner=%0d exp 1/0/4", busy_f, to_f, owner_f);
        end
        rdy_f = 1'b1; dma_f = 8'h00;
        tick();
        rdy_f = 1'b0;
    endtask

    task automatic test_ready_at_limit();
        dma_f = 8'b00010000; rdy_f = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        checks++;
        if (busy_f !== 1'b1) begin
            errors++;
            $display("FAIL limit_busy busy=%b exp 1", busy_f);
        end
        rdy_f = 1'b1; dma_f = 8'h00;
        tick();
        #2;
        checks++;
        if (busy_f !== 1'b0 || to_f !== 1'b0 || req_f !== 1'b0) begin
            errors++;
            $display("FAIL limit_ready busy=%b to=%b req=%b exp 0/0/0", busy_f, to_f, req_f);
        end
        tick();
        #2;
        checks++;
        if (to_f !== 1'b0) begin
            errors++;
            $display("FAIL limit_nopulse to=%b exp 0", to_f);
        end
        rdy_f = 1'b0;
    endtask

    task automatic test_rr_sequence();
        logic [7:0] exp_g;
        tick();
        dma_r = 8'hFF; rdy_r = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_g = 8'h01 << (i % 8);
            #2;
            checks++;
            if (grant_r !== exp_g || busy_r !== 1'b0) begin
                errors++;
                $display("FAIL rr_seq%0d grant=%h busy=%b exp %h/0", i, grant_r, busy_r, exp_g);
            end
            tick();
        end
        dma_r = 8'h00; rdy_r = 1'b0;
    endtask

    task automatic test_no_timeout();
        dma_r = 8'b00000101; rdy_r = 1'b0;
        #2;
        checks++;
        if (grant_r !== 8'h04) begin
            errors++;
            $display("FAIL rr_after_wrap grant=%h exp 04", grant_r);
        end
        tick();
        for (int i = 0; i < 300; i++) begin
            #2;
            checks++;
            if (busy_r !== 1'b1 || to_r !== 1'b0 || grant_r !== 8'h04) begin
                errors++;
                $display("FAIL notimeout_hold%0d busy=%b to=%b grant=%h exp 1/0/04", i, busy_r, to_r, grant_r);
            end
            tick();
        end
        rdy_r = 1'b1;
        tick();
        #2;
        checks++;
        if (grant_r !== 8'h01 || busy_r !== 1'b0) begin
            errors++;
            $display("FAIL rr_rearb grant=%h busy=%b exp 01/0", grant_r, busy_r);
        end
        dma_r = 8'h00; rdy_r = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        tick();
        dma_f = 8'b00001000; rdy_f = 1'b0;
        tick();
        #2;
        checks++;
        if (busy_f !== 1'b1 || owner_f !== 3'd3) begin
            errors++;
            $display("FAIL midrst_busy busy=%b owner=%0d exp 1/3", busy_f, owner_f);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (grant_f !== 8'h00 || busy_f !== 1'b0 || req_f !== 1'b0 || owner_f !== 3'd0) begin
            errors++;
            $display("FAIL midrst_drop grant=%h busy=%b req=%b owner=%0d exp 00/0/0/0", grant_f, busy_f, req_f, owner_f);
        end
        tick();
        clr = 1'b1; dma_f = 8'h00; rdy_f = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (req_f !== 1'b0 || busy_f !== 1'b0 || to_f !== 1'b0) begin
                errors++;
                $display("FAIL midrst_after%0d req=%b busy=%b to=%b exp 0/0/0", i, req_f, busy_f, to_f);
            end
            tick();
        end
        rdy_f = 1'b0;
    endtask

    task automatic test_random_rr5();
        int wait_cnt[5];
        int worst;
        for (int m = 0; m < 5; m++) wait_cnt[m] = 0;
        for (int c = 0; c < 2000; c++) begin
            dma_5 = 5'($urandom_range(0, 31));
            rdy_5 = 1'($urandom_range(0, 1));
            #2;
            checks++;
            if ((grant_5 & (grant_5 - 5'd1)) !== 5'd0 || req_5 !== (|grant_5) ||
                (grant_5 != 5'd0 && grant_5 !== (5'd1 << owner_5)) ||
                (grant_5 == 5'd0 && owner_5 !== 3'd0)) begin
                errors++;
                $display("FAIL rand_onehot c=%0d grant=%b owner=%0d req=%b", c, grant_5, owner_5, req_5);
            end
            if (req_5 && !busy_5) begin
                worst = 0;
                for (int m = 0; m < 5; m++) begin
                    if (m == int'(owner_5)) wait_cnt[m] = 0;
                    else if (dma_5[m]) wait_cnt[m]++;
                    else wait_cnt[m] = 0;
                    if (wait_cnt[m] > worst) worst = wait_cnt[m];
                end
                checks++;
                if (worst > 4) begin
                    errors++;
                    $display("FAIL rand_starve c=%0d wait=%0d exp <=4", c, worst);
                end
            end
            tick();
        end
        dma_5 = 5'd0; rdy_5 = 1'b0;
    endtask

    initial begin
        clr = 1'b0;
        dma_f = 8'h00; rdy_f = 1'b0;
        dma_r = 8'h00; rdy_r = 1'b0;
        dma_5 = 5'd0;  rdy_5 = 1'b0;
        test_reset();
        test_fixed_hold();
        test_timeout();
        test_ready_at_limit();
        test_rr_sequence();
        test_no_timeout();
        test_reset_mid_busy();
        test_random_rr5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 8, number of DMA requesters (2..16).
REQ-002 Parameter RR_MODE, default 0; 0 = fixed priority (master 0 highest), 1 = round-robin.
REQ-003 Parameter TIMEOUT, default 255, max BUSY cycles before forced release; 0 disables timeout.
REQ-004 Parameter CNT_W, default 8, timeout counter width; SHALL hold TIMEOUT.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 clr  input  1  reset, asynchronous, active-low.
REQ-007 dma  input  N_MASTERS  per-master bus request, level-sensitive.
REQ-008 ready  input  1  slave transfer-complete strobe; qualified by req.
REQ-009 grant  output  N_MASTERS  one-hot grant; all-zero when no owner.
REQ-010 req  output  1  OR of grant; bus claimed.
REQ-011 owner  output  clog2(N_MASTERS)  index of granted master; 0 when grant is zero.
REQ-012 busy  output  1  high while in BUSY state.
REQ-013 timeout  output  1  one-cycle pulse when a BUSY grant is force-released.

Function
REQ-014 FSM has two states: IDLE and BUSY.
REQ-015 IDLE: grant SHALL be the combinational arbitration winner of current dma (zero latency).
REQ-016 Fixed mode: winner = lowest-index asserted dma bit.
REQ-017 RR mode: winner = first asserted bit searching upward from (last_owner+1) mod N_MASTERS, wrapping.
REQ-018 IDLE, req=1, ready=1 same cycle: single-cycle transfer; stay IDLE; last_owner <= winner.
REQ-019 IDLE, req=1, ready=0: go BUSY; grant_reg <= winner; counter <= 0.
REQ-020 IDLE, req=0: stay IDLE; ready ignored; last_owner unchanged.
REQ-021 BUSY: grant SHALL equal grant_reg; dma changes (including owner deasserting) SHALL NOT alter grant.
REQ-022 BUSY, ready=1: go IDLE next cycle; last_owner <= owner; counter cleared.
REQ-023 BUSY, ready=0: counter increments by 1 per cycle, saturating at TIMEOUT.
REQ-024 BUSY, TIMEOUT!=0, counter==TIMEOUT-1 and ready=0: go IDLE; timeout pulses next cycle; last_owner <= owner.
REQ-025 ready and timeout condition in same cycle: treated as ready; no timeout pulse.
REQ-026 After release (ready or timeout) re-arbitration occurs combinationally in the following IDLE cycle.
REQ-027 TIMEOUT=0: BUSY persists until ready, counter held at 0.
REQ-028 grant SHALL be one-hot or zero in every cycle; owner consistent with grant.
REQ-029 Fixed mode: last_owner register exists but does not affect arbitration.

Reset
REQ-030 clr low: state IDLE, grant_reg 0, counter 0, timeout 0, last_owner N_MASTERS-1 (master 0 first in RR), asynchronously.
REQ-031 During reset grant, req, owner reflect IDLE combinational path gated to zero; busy 0.
REQ-032 Reset asserted mid-BUSY: grant drops immediately; no timeout pulse on release of reset.

Verification
REQ-033 Fixed, dma=8'b00101100, ready=0 -> grant=8'b00000100, owner=2, busy=1 next cycle; dma->8'b00000001 keeps grant=8'b00000100.
REQ-034 RR, dma=8'hFF held, ready=1 every cycle -> grant sequence 0x01,0x02,0x04...0x80,0x01 (wrap), busy stays 0.
REQ-035 TIMEOUT=4, dma=8'b00010000, ready=0 forever -> busy for 4 cycles, then IDLE, timeout=1 for one cycle, grant re-issued to master 4.
REQ-036 TIMEOUT=4, ready=1 on 4th BUSY cycle -> normal release, timeout stays 0.
REQ-037 BUSY owner=3, clr pulsed low -> grant=0, busy=0 immediately; after clr high with dma=0 -> req=0, ready ignored.
REQ-038 Random dma/ready, N_MASTERS=5, RR mode -> grant always one-hot or zero; no requester starved more than 4 grants.
